meta_data_unrotator: RTL
========================

// Module: meta_data_unrotator
// PURPOSE
//  Inverse of the word-granular metadata rotation. It restores per-word metadata
//  (bit width, mid value, conv flag, per-byte bool flags) to original word order.
//  Sits on the dequantizer side: rotated metadata arrives with its rotation
//  amount and is un-rotated before words are reconstructed.
//  Multi-cycle log-shifter: one binary stage per clock, valid/ready on both sides.
// PARAMETERS
//  WordWidth_WIDTH        32  width of one MidArray word
//  NumOfBytesInWord       4   isBool bits per word
//  NumberOfRotationWidth  5   rotation-amount width; equals log2(MAXNUMWORD)
//  MAXNUMWORD             32  words per block; must be a power of two
// PORTS
//  clk                    in   1                         clock, rising edge
//  rst                    in   1                         async active-low reset
//  in_valid               in   1                         input bundle valid
//  in_ready               out  1                         block can accept
//  numberOfRotation       in   NumberOfRotationWidth     rotation applied upstream (words)
//  bitWidthArray          in   5*MAXNUMWORD              rotated bit widths, word j at [5j+:5]
//  MidArray               in   WordWidth_WIDTH*MAXNUMWORD  rotated mids
//  ConvArray              in   MAXNUMWORD                rotated conv flags
//  isBoolArray            in   NumOfBytesInWord*MAXNUMWORD rotated bool flags
//  out_valid              out  1                         restored bundle valid
//  out_ready              in   1                         downstream accepts
//  RestoredbitWidthArray  out  5*MAXNUMWORD              restored bit widths
//  RestoredMidArray       out  WordWidth_WIDTH*MAXNUMWORD  restored mids
//  RestoredConvArray      out  MAXNUMWORD                restored conv flags
//  RestoredisBoolArray    out  NumOfBytesInWord*MAXNUMWORD restored bool flags
// BEHAVIOUR
//  - Clocking: one clock (clk); rst is asynchronous and active-low.
//  - Function: restored word i = input word ((i - n) mod MAXNUMWORD), where
//    n = numberOfRotation. All four arrays use the same n. A rotator mapping
//    out[i] = in[(i+n) mod MAXNUMWORD] followed by this block is the identity.
//  - States: IDLE, SHIFT, DONE. The encoding is free.
//  - IDLE: in_ready=1, out_valid=0. On in_valid&in_ready, capture the four arrays
//    into the working registers, capture n, set stage counter k=0, go to SHIFT.
//  - SHIFT: in_ready=0. Each cycle, if n[k]=1, rotate every working array by 2^k
//    words toward higher word index (word i <- word i-2^k, mod MAXNUMWORD).
//    Then k<=k+1. After stage k=NumberOfRotationWidth-1, go to DONE.
//  - DONE: out_valid=1 and the outputs are stable. On out_ready, go to IDLE.
//    In_ready stays 0 in DONE; there is no overlap of bundles.
//  - Latency: out_valid rises exactly NumberOfRotationWidth cycles after the
//    acceptance edge (5 by default), independent of n. n=0 still takes 5 cycles.
//  - Throughput: at best one bundle per NumberOfRotationWidth+2 cycles.
//  - Outputs: driven directly from the working registers. They are meaningful
//    only while out_valid=1 and are held unchanged while out_valid & ~out_ready.
//  - Input: sampled only at acceptance. Later changes to the inputs are ignored.
//  - Reset, at any time including mid-SHIFT or in DONE: state=IDLE, out_valid=0,
//    all Restored* outputs = 0, k=0, captured n=0. In-flight data is discarded.
//    In_ready rises once rst is deasserted.
//  - Wrap-around: every rotation is modulo MAXNUMWORD, and n=MAXNUMWORD-1 is legal.
//    No rotation uses an out-of-range bit index; there is no -1 offset for n=0.
//  - Width rules: rotation step per array = 2^k * per-word width (5, WordWidth_WIDTH,
//    1, NumOfBytesInWord bits). No arithmetic is applied to the field contents.
// TESTING
//  1. MidArray word j=j, others 0, n=3 -> after 5 cycles out_valid=1;
//     RestoredMid word0=29, word3=0, word31=28.
//  2. n=0, random arrays -> outputs bit-identical to inputs, out_valid at cycle 5.
//  3. n=31, ConvArray=32'h0000_0001 -> RestoredConvArray=32'h8000_0000;
//     bitWidth word0=5'd7 -> word31=7.
//  4. Round trip: random arrays and random n through a reference rotator, then
//     this block -> equals the originals. 1000 iterations.
//  5. Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0.
//     Pulse out_ready -> IDLE, in_ready=1 the next cycle.
//  6. Assert rst at SHIFT stage 2 -> out_valid=0, outputs=0 immediately. After
//     release, a new bundle with n=1 restores correctly.

Source files
------------

// File: rtl/meta_data_unrotator.sv
// meta_data_unrotator
// Restores rotated per-word metadata (bit width, mid value, conv flag, per-byte
// bool flags) to original word order. A log shifter applies one binary stage
// per clock: stage k rotates every working array by 2^k words toward higher
// word index when bit k of the captured rotation amount is set. The result
// appears NumberOfRotationWidth cycles after acceptance, whatever the amount.
//
// state | meaning
// IDLE  | waiting for a bundle; in_ready=1 except the first cycle after reset
// SHIFT | applying stage k of the un-rotation; no new bundle accepted
// DONE  | out_valid=1, outputs held until out_ready

module meta_data_unrotator #(
    parameter int WordWidth_WIDTH       = 32,
    parameter int NumOfBytesInWord      = 4,
    parameter int NumberOfRotationWidth = 5,
    parameter int MAXNUMWORD            = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NumberOfRotationWidth-1:0]       numberOfRotation,
    input  logic [5*MAXNUMWORD-1:0]                bitWidthArray,
    input  logic [WordWidth_WIDTH*MAXNUMWORD-1:0]  MidArray,
    input  logic [MAXNUMWORD-1:0]                  ConvArray,
    input  logic [NumOfBytesInWord*MAXNUMWORD-1:0] isBoolArray,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [5*MAXNUMWORD-1:0]                RestoredbitWidthArray,
    output logic [WordWidth_WIDTH*MAXNUMWORD-1:0]  RestoredMidArray,
    output logic [MAXNUMWORD-1:0]                  RestoredConvArray,
    output logic [NumOfBytesInWord*MAXNUMWORD-1:0] RestoredisBoolArray
);

    localparam int RW = NumberOfRotationWidth;
    localparam int KW = (RW > 1) ? $clog2(RW) : 1;
    localparam int BW = 5;
    localparam int MW = WordWidth_WIDTH;
    localparam int NB = NumOfBytesInWord;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                   state;
    logic [KW-1:0]            k;
    logic [RW-1:0]            n;
    logic                     rdy;
    logic                     vld;

    logic [BW*MAXNUMWORD-1:0] bw_w,   bw_rot;
    logic [MW*MAXNUMWORD-1:0] mid_w,  mid_rot;
    logic [MAXNUMWORD-1:0]    conv_w, conv_rot;
    logic [NB*MAXNUMWORD-1:0] bool_w, bool_rot;

    // Word index that lands on word i after a stage-kk rotation (wraps mod MAXNUMWORD).
    function automatic int src_word(input int i, input logic [KW-1:0] kk);
        return (i - (1 << kk)) & (MAXNUMWORD - 1);
    endfunction

    // Candidate result of the current stage: every array moved up by 2^k words.
    always_comb begin
        bw_rot   = '0;
        mid_rot  = '0;
        conv_rot = '0;
        bool_rot = '0;
        for (int i = 0; i < MAXNUMWORD; i++) begin
            bw_rot[BW*i +: BW]   = bw_w[BW*src_word(i, k) +: BW];
            mid_rot[MW*i +: MW]  = mid_w[MW*src_word(i, k) +: MW];
            conv_rot[i]          = conv_w[src_word(i, k)];
            bool_rot[NB*i +: NB] = bool_w[NB*src_word(i, k) +: NB];
        end
    end

    // Handshake FSM, stage counter and working registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            rdy    <= 1'b0;
            vld    <= 1'b0;
            k      <= '0;
            n      <= '0;
            bw_w   <= '0;
            mid_w  <= '0;
            conv_w <= '0;
            bool_w <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rdy && in_valid) begin
                        bw_w   <= bitWidthArray;
                        mid_w  <= MidArray;
                        conv_w <= ConvArray;
                        bool_w <= isBoolArray;
                        n      <= numberOfRotation;
                        k      <= '0;
                        rdy    <= 1'b0;
                        state  <= SHIFT;
                    end else begin
                        rdy <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (n[k]) begin
                        bw_w   <= bw_rot;
                        mid_w  <= mid_rot;
                        conv_w <= conv_rot;
                        bool_w <= bool_rot;
                    end
                    if (k == KW'(RW - 1)) begin
                        k     <= '0;
                        vld   <= 1'b1;
                        state <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        vld   <= 1'b0;
                        rdy   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    rdy   <= 1'b0;
                    vld   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready              = rdy;
    assign out_valid             = vld;
    assign RestoredbitWidthArray = bw_w;
    assign RestoredMidArray      = mid_w;
    assign RestoredConvArray     = conv_w;
    assign RestoredisBoolArray   = bool_w;

endmodule
